imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface that if_stage reads.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_word_packer.sv | 43 ++++
 rtl/imem_loader.sv | 133 +++++++++++++
 tb/tb_imem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader state encodings
// and the default terminator word.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_RECV  = 3'd1,
    LD_WRITE = 3'd2,
    LD_DONE  = 3'd3,
    LD_ERROR = 3'd4
  } ld_state_t;

  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Packs accepted bytes MSB first into 32-bit words; flags the cycle in which
// the fourth byte of a word is being accepted.
module imem_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_ready_o
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear_i) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (accept_i) begin
      shift_d = {shift_q[15:0], byte_i};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The word is complete combinationally while its last byte is on the bus,
  // so the loader can register it on the same edge that accepts that byte.
  assign word_o       = {shift_q, byte_i};
  assign word_ready_o = accept_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory as 32-bit words, holding the CPU
// in reset until a terminator word has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic                  i_rx_valid,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [31:0]           o_imem_wdata,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_error,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic [2:0]            o_dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   WC_ONE    = 1;

  // Handshake: a byte transfers on a rising edge where i_rx_valid and
  // o_rx_ready are both high; the source must hold the byte until then.
  ld_state_t             state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   word_count_q;
  logic                  rx_ready_q;
  logic                  imem_we_q;
  logic [ADDR_WIDTH-1:0] imem_addr_q;
  logic [31:0]           imem_wdata_q;
  logic                  cpu_reset_q;
  logic                  done_q;
  logic                  error_q;

  logic        accept;
  logic        start_take;
  logic [31:0] word;
  logic        word_ready;

  assign accept     = i_rx_valid && rx_ready_q;
  assign start_take = i_start && (state_q == LD_IDLE || state_q == LD_DONE ||
                                  state_q == LD_ERROR);

  imem_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_take),
    .accept_i     (accept),
    .byte_i       (i_rx_data),
    .word_o       (word),
    .word_ready_o (word_ready)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= LD_IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      imem_we_q <= 1'b0;
      case (state_q)
        LD_IDLE, LD_DONE, LD_ERROR: begin
          if (i_start) begin
            state_q      <= LD_RECV;
            addr_q       <= '0;
            word_count_q <= '0;
            rx_ready_q   <= 1'b1;
            cpu_reset_q  <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        LD_RECV: begin
          if (word_ready) begin
            state_q      <= LD_WRITE;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b1;
            imem_addr_q  <= addr_q;
            imem_wdata_q <= word;
          end
        end
        LD_WRITE: begin
          word_count_q <= word_count_q + WC_ONE;
          addr_q       <= addr_q + ADDR_ONE;
          // The terminator wins even when it lands in the last slot.
          if (imem_wdata_q == HALT_WORD) begin
            state_q     <= LD_DONE;
            cpu_reset_q <= 1'b0;
            done_q      <= 1'b1;
          end else if (addr_q == LAST_ADDR) begin
            state_q <= LD_ERROR;
            error_q <= 1'b1;
          end else begin
            state_q    <= LD_RECV;
            rx_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= LD_IDLE;
          rx_ready_q  <= 1'b0;
          cpu_reset_q <= 1'b1;
          done_q      <= 1'b0;
          error_q     <= 1'b0;
        end
      endcase
    end
  end

  assign o_rx_ready   = rx_ready_q;
  assign o_imem_we    = imem_we_q;
  assign o_imem_addr  = imem_addr_q;
  assign o_imem_wdata = imem_wdata_q;
  assign o_cpu_reset  = cpu_reset_q;
  assign o_done       = done_q;
  assign o_error      = error_q;
  assign o_word_count = word_count_q;
  assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: an 8-bit-address instance for the normal
// loads and a 2-bit-address instance for the overflow case.
module tb_imem_loader;

  logic clk;
  logic reset;

  logic       start_b, valid_b;
  logic [7:0] data_b;
  logic       ready_b, we_b, cpu_reset_b, done_b, error_b;
  logic [7:0] addr_b;
  logic [31:0] wdata_b;
  logic [8:0] wc_b;
  logic [2:0] st_b;

  logic       start_s, valid_s;
  logic [7:0] data_s;
  logic       ready_s, we_s, cpu_reset_s, done_s, error_s;
  logic [1:0] addr_s;
  logic [31:0] wdata_s;
  logic [2:0] wc_s;
  logic [2:0] st_s;

  int errors = 0;
  int checks = 0;

  logic [39:0] exp_q[$];
  logic [39:0] exp_q_s[$];

  imem_loader #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .i_start(start_b), .i_rx_valid(valid_b),
    .i_rx_data(data_b), .o_rx_ready(ready_b), .o_imem_we(we_b),
    .o_imem_addr(addr_b), .o_imem_wdata(wdata_b), .o_cpu_reset(cpu_reset_b),
    .o_done(done_b), .o_error(error_b), .o_word_count(wc_b), .o_dbg_state(st_b)
  );

  imem_loader #(.ADDR_WIDTH(2)) dut_s (
    .clk(clk), .reset(reset), .i_start(start_s), .i_rx_valid(valid_s),
    .i_rx_data(data_s), .o_rx_ready(ready_s), .o_imem_we(we_s),
    .o_imem_addr(addr_s), .o_imem_wdata(wdata_s), .o_cpu_reset(cpu_reset_s),
    .o_done(done_s), .o_error(error_s), .o_word_count(wc_s), .o_dbg_state(st_s)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard monitors: every write must match the next expected entry, and
  // no byte may be accepted while the write strobe is up.
  always @(negedge clk) begin
    if (!reset && we_b) begin
      logic [39:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 40'hDE_DEAD_BEEF;
      chk("write_b", {addr_b, wdata_b}, e);
      chk("ready_in_write_b", ready_b, 1'b0);
    end
    if (!reset && we_s) begin
      logic [39:0] e;
      e = (exp_q_s.size() > 0) ? exp_q_s.pop_front() : 40'hDE_DEAD_BEEF;
      chk("write_s", {6'd0, addr_s, wdata_s}, e);
      chk("ready_in_write_s", ready_s, 1'b0);
    end
  end

  // Driver tasks; all are entered and left just after a rising edge.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    if (sel) begin valid_s = 1'b1; data_s = b; end
    else     begin valid_b = 1'b1; data_b = b; end
    forever begin
      @(negedge clk);
      if ((sel ? ready_s : ready_b) === 1'b1) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $error("FAIL byte_timeout: got no ready expected ready within 100 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic stop_rx(input bit sel);
    if (sel) valid_s = 1'b0; else valid_b = 1'b0;
  endtask

  // Sends one word MSB first and records the write it must produce.
  task automatic send_word(input bit sel, input logic [7:0] a, input logic [31:0] w);
    if (sel) exp_q_s.push_back({6'd0, a[1:0], w});
    else     exp_q.push_back({a, w});
    send_byte(sel, w[31:24]);
    send_byte(sel, w[23:16]);
    send_byte(sel, w[15:8]);
    send_byte(sel, w[7:0]);
  endtask

  task automatic pulse_start(input bit sel);
    if (sel) start_s = 1'b1; else start_b = 1'b1;
    @(posedge clk); #1;
    if (sel) start_s = 1'b0; else start_b = 1'b0;
  endtask

  task automatic wait_end(input bit sel);
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (sel ? (done_s | error_s) : (done_b | error_b)) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $error("FAIL end_timeout: got no done/error expected one within 300 cycles");
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input bit sel);
    repeat (10) @(negedge clk);
    chk(sel ? "drain_s" : "drain_b", sel ? exp_q_s.size() : exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    start_b = 0; valid_b = 0; data_b = 0;
    start_s = 0; valid_s = 0; data_s = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_cpu_reset", cpu_reset_b, 1'b1);
    chk("rst_done", done_b, 1'b0);
    chk("rst_error", error_b, 1'b0);
    chk("rst_ready", ready_b, 1'b0);
    chk("rst_we", we_b, 1'b0);
    chk("rst_wc", wc_b, 9'd0);
    chk("rst_state", st_b, 3'd0);
    @(posedge clk); #1;

    // Idle input: byte offered without start is never taken.
    valid_b = 1'b1; data_b = 8'hAA;
    repeat (5) @(negedge clk);
    chk("idle_ready", ready_b, 1'b0);
    chk("idle_cpu_reset", cpu_reset_b, 1'b1);
    chk("idle_wc", wc_b, 9'd0);
    chk("idle_state", st_b, 3'd0);
    @(posedge clk); #1;
    stop_rx(0);

    // Reset mid-load after two bytes; stale bytes must vanish.
    pulse_start(0);
    send_byte(0, 8'hDE);
    send_byte(0, 8'hAD);
    stop_rx(0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cpu_reset", cpu_reset_b, 1'b1);
    chk("async_rst_ready", ready_b, 1'b0);
    chk("async_rst_state", st_b, 3'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    pulse_start(0);
    send_word(0, 8'd0, 32'h0000_0001);
    stop_rx(0);
    drain(0);
    chk("t1_wc", wc_b, 9'd1);
    chk("t1_done", done_b, 1'b0);

    // Three-word load with gaps between words.
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    pulse_start(0);
    send_word(0, 8'd0, 32'h2008_0005);
    stop_rx(0); repeat (3) @(posedge clk); #1;
    send_word(0, 8'd1, 32'h0000_0000);
    stop_rx(0); repeat (2) @(posedge clk); #1;
    send_word(0, 8'd2, 32'hFFFF_FFFF);
    stop_rx(0);
    wait_end(0);
    chk("t2_wc", wc_b, 9'd3);
    chk("t2_done", done_b, 1'b1);
    chk("t2_cpu_reset", cpu_reset_b, 1'b0);
    chk("t2_error", error_b, 1'b0);
    drain(0);

    // Reload from DONE with only the terminator.
    pulse_start(0);
    @(negedge clk);
    chk("t5_cpu_reset_held", cpu_reset_b, 1'b1);
    chk("t5_done_clear", done_b, 1'b0);
    chk("t5_wc_clear", wc_b, 9'd0);
    @(posedge clk); #1;
    send_word(0, 8'd0, 32'hFFFF_FFFF);
    stop_rx(0);
    wait_end(0);
    chk("t5_wc", wc_b, 9'd1);
    chk("t5_done", done_b, 1'b1);
    chk("t5_cpu_reset", cpu_reset_b, 1'b0);
    drain(0);

    // Back-pressure: valid never drops across three words.
    pulse_start(0);
    send_word(0, 8'd0, 32'hA1B2_C3D4);
    send_word(0, 8'd1, 32'h1234_5678);
    send_word(0, 8'd2, 32'hFFFF_FFFF);
    stop_rx(0);
    wait_end(0);
    chk("t3_wc", wc_b, 9'd3);
    chk("t3_done", done_b, 1'b1);
    drain(0);

    // Partial all-ones word at a stall must not look like the terminator.
    pulse_start(0);
    send_byte(0, 8'hFF);
    send_byte(0, 8'hFF);
    send_byte(0, 8'hFF);
    stop_rx(0);
    repeat (6) @(negedge clk);
    chk("partial_done", done_b, 1'b0);
    chk("partial_state", st_b, 3'd1);
    chk("partial_wc", wc_b, 9'd0);
    @(posedge clk); #1;
    exp_q.push_back({8'd0, 32'hFFFF_FF00});
    send_byte(0, 8'h00);
    stop_rx(0);
    drain(0);
    chk("partial_wc_after", wc_b, 9'd1);
    chk("partial_done_after", done_b, 1'b0);

    // Overflow on the 4-word instance, then recovery from ERROR.
    pulse_start(1);
    for (int i = 0; i < 4; i++)
      send_word(1, 8'(i), 32'h1111_1111 * (i + 1));
    stop_rx(1);
    wait_end(1);
    chk("t4_error", error_s, 1'b1);
    chk("t4_cpu_reset", cpu_reset_s, 1'b1);
    chk("t4_wc", wc_s, 3'd4);
    chk("t4_done", done_s, 1'b0);
    chk("t4_ready", ready_s, 1'b0);
    drain(1);
    pulse_start(1);
    send_word(1, 8'd0, 32'hFFFF_FFFF);
    stop_rx(1);
    wait_end(1);
    chk("t4_recover_done", done_s, 1'b1);
    chk("t4_recover_error", error_s, 1'b0);
    chk("t4_recover_wc", wc_s, 3'd1);
    drain(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
